// File: rtl/seq_addsub_chunked.sv
// Multi-cycle two's-complement adder/subtractor.
// Adds a WIDTH-bit operand pair CHUNK bits per clock, carrying between chunks
// through a register. Valid/ready handshake on both the operand and result side.
// WIDTH must be a multiple of CHUNK and at least 2.
module seq_addsub_chunked #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carryout,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;         // shifted right one chunk per RUN cycle
    logic [WIDTH-1:0] r_b;         // already inverted for subtract
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_acc;       // partial sum, filled from the top down
    logic [WIDTH-1:0] r_sum;
    logic             r_carryout;
    logic             r_overflow;
    logic             r_zero;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [CHUNK:0]         w_chunk;
    logic                   w_c_msb;
    logic [WIDTH+CHUNK-1:0] w_cat;
    logic [WIDTH-1:0]       w_acc_next;
    logic                   w_last;

    // Chunk adder on the low chunk of the shifting operand registers.
    always_comb begin
        w_chunk    = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + (CHUNK+1)'(r_carry);
        // Carry into the chunk's top bit, recovered from that bit's sum and inputs.
        w_c_msb    = w_chunk[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];
        w_cat      = {w_chunk[CHUNK-1:0], r_acc};
        w_acc_next = w_cat[WIDTH+CHUNK-1:CHUNK];
        w_last     = (r_idx == LAST_IDX);
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_carryout  <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_a        <= i_a;
                        r_b        <= i_sub ? ~i_b : i_b;
                        r_carry    <= i_sub;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= StRun;
                    end
                end
                StRun: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_acc   <= w_acc_next;
                    r_carry <= w_chunk[CHUNK];
                    r_idx   <= r_idx + IW'(1);
                    if (w_last) begin
                        // Result registers only change here, so observers never see a partial sum.
                        r_sum       <= w_acc_next;
                        r_carryout  <= w_chunk[CHUNK];
                        r_overflow  <= w_chunk[CHUNK] ^ w_c_msb;
                        r_zero      <= (w_acc_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_sum       = r_sum;
    assign o_carryout  = r_carryout;
    assign o_overflow  = r_overflow;
    assign o_zero      = r_zero;

endmodule

// File: tb/tb_seq_addsub_chunked.sv
// Self-checking bench for seq_addsub_chunked: directed cases on CHUNK=4 and a
// random sweep over CHUNK in {1,4,16}, with a queue-based scoreboard.
module tb_seq_addsub_chunked;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        logic         z;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [W-1:0] sum_o     [3];
    logic         co_o      [3];
    logic         ov_o      [3];
    logic         z_o       [3];

    int   n_checks;
    int   n_pass;
    exp_t sb [$];
    int   nch_tab [3];

    seq_addsub_chunked #(.WIDTH(W), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
        .i_a(a), .i_b(b), .i_sub(sub), .o_out_valid(out_valid[0]),
        .i_out_ready(out_ready[0]), .o_sum(sum_o[0]), .o_carryout(co_o[0]),
        .o_overflow(ov_o[0]), .o_zero(z_o[0])
    );

    seq_addsub_chunked #(.WIDTH(W), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
        .i_a(a), .i_b(b), .i_sub(sub), .o_out_valid(out_valid[1]),
        .i_out_ready(out_ready[1]), .o_sum(sum_o[1]), .o_carryout(co_o[1]),
        .o_overflow(ov_o[1]), .o_zero(z_o[1])
    );

    seq_addsub_chunked #(.WIDTH(W), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
        .i_a(a), .i_b(b), .i_sub(sub), .o_out_valid(out_valid[2]),
        .i_out_ready(out_ready[2]), .o_sum(sum_o[2]), .o_carryout(co_o[2]),
        .o_overflow(ov_o[2]), .o_zero(z_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    // Reference: full-width add with an extra bit, overflow from operand/result signs.
    function automatic exp_t model_fn(input logic [W-1:0] av, input logic [W-1:0] bv,
                                      input logic sv);
        logic [W-1:0] bb;
        logic [W:0]   full;
        exp_t         e;
        bb   = sv ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, sv};
        e.sum = full[W-1:0];
        e.co  = full[W];
        e.ov  = (av[W-1] == bb[W-1]) && (e.sum[W-1] != av[W-1]);
        e.z   = (e.sum == '0);
        return e;
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_result(input int k);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("sum", {16'd0, sum_o[k]}, {16'd0, e.sum});
        check("carryout", {31'd0, co_o[k]}, {31'd0, e.co});
        check("overflow", {31'd0, ov_o[k]}, {31'd0, e.ov});
        check("zero", {31'd0, z_o[k]}, {31'd0, e.z});
    endtask

    // Wait for out_valid (bounded), check latency counted from the accepting edge.
    task automatic wait_result(input int k);
        int n;
        n = 0;
        while (!out_valid[k] && n < 100) begin
            step();
            n++;
        end
        check("latency", n, nch_tab[k]);
    endtask

    task automatic run_op(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv);
        int n;
        a = av;
        b = bv;
        sub = sv;
        in_valid[k] = 1'b1;
        n = 0;
        while (!in_ready[k] && n < 50) begin
            step();
            n++;
        end
        if (!in_ready[k]) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid[k] = 1'b0;
            return;
        end
        step();
        in_valid[k] = 1'b0;
        sb.push_back(model_fn(av, bv, sv));
        wait_result(k);
        compare_result(k);
        out_ready[k] = 1'b1;
        step();
        out_ready[k] = 1'b0;
        check("out_valid_fall", {31'd0, out_valid[k]}, 32'd0);
        check("in_ready_back", {31'd0, in_ready[k]}, 32'd1);
    endtask

    initial begin
        exp_t held;
        n_checks = 0;
        n_pass = 0;
        nch_tab[0] = 16;
        nch_tab[1] = 4;
        nch_tab[2] = 1;
        rst_n = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b0;
        end
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_in_ready", {31'd0, in_ready[1]}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid[1]}, 32'd0);
        check("rst_sum", {16'd0, sum_o[1]}, 32'd0);
        check("rst_flags", {29'd0, co_o[1], ov_o[1], z_o[1]}, 32'd0);

        // Directed add/sub cases on CHUNK=4
        run_op(1, 16'h0001, 16'h0001, 1'b0);
        run_op(1, 16'h7FFF, 16'h0001, 1'b0);
        run_op(1, 16'hFFFF, 16'h0001, 1'b0);
        run_op(1, 16'h8000, 16'h0001, 1'b1);
        run_op(1, 16'h0002, 16'h0003, 1'b1);

        // Back-pressure with a pending pair toggling on the inputs
        a = 16'h1111;
        b = 16'h2222;
        sub = 1'b0;
        in_valid[1] = 1'b1;
        step();
        sb.push_back(model_fn(16'h1111, 16'h2222, 1'b0));
        wait_result(1);
        held = sb[0];
        for (int i = 0; i < 10; i++) begin
            a = (i % 2 == 0) ? 16'hAAAA : 16'h0F0F;
            b = (i % 2 == 0) ? 16'h5555 : 16'h0101;
            sub = (i % 2 == 0);
            step();
            check("bp_in_ready", {31'd0, in_ready[1]}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid[1]}, 32'd1);
            check("bp_sum", {16'd0, sum_o[1]}, {16'd0, held.sum});
            check("bp_flags", {29'd0, co_o[1], ov_o[1], z_o[1]},
                  {29'd0, held.co, held.ov, held.z});
        end
        // Last toggle left a=0x0F0F, b=0x0101, sub=0 pending.
        compare_result(1);
        out_ready[1] = 1'b1;
        step();
        out_ready[1] = 1'b0;
        check("bp_idle_ready", {31'd0, in_ready[1]}, 32'd1);
        step();
        in_valid[1] = 1'b0;
        sb.push_back(model_fn(16'h0F0F, 16'h0101, 1'b0));
        check("bp_pending_taken", {31'd0, in_ready[1]}, 32'd0);
        wait_result(1);
        compare_result(1);
        out_ready[1] = 1'b1;
        step();
        out_ready[1] = 1'b0;

        // Reset mid-RUN: abort with no clock edge needed
        a = 16'hABCD;
        b = 16'h1357;
        sub = 1'b0;
        in_valid[1] = 1'b1;
        step();
        in_valid[1] = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready[1]}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid[1]}, 32'd0);
        check("mid_rst_sum", {16'd0, sum_o[1]}, 32'd0);
        check("mid_rst_flags", {29'd0, co_o[1], ov_o[1], z_o[1]}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_op(1, 16'h1234, 16'h4321, 1'b0);

        // Random sweep over the three chunk widths
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 500; i++) begin
                run_op(k, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_addsub_chunked.md
Name: seq_addsub_chunked

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor. Successor to the single-cycle 4-bit structural ripple adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry between chunks through a register.
- Reports sum, carryout, signed overflow and zero. Uses a valid/ready handshake on both input and output, so it can sit between ALU operand registers and the writeback stage.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK and at least 2.
- CHUNK, 4, bits processed per cycle. NCH = WIDTH/CHUNK chunk cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair presented
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH  first operand, two's complement
- b  input  WIDTH  second operand, two's complement
- sub  input  1  0: a+b, 1: a-b; sampled with operands
- out_valid  output  1  result registers hold a completed result
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result, modulo 2^WIDTH
- carryout  output  1  carry out of MSB; for sub, 1 means no borrow
- overflow  output  1  signed overflow
- zero  output  1  sum == 0

Behaviour:
- Reset (async assert, sync release): state = IDLE. in_ready=1, out_valid=0, sum=0, carryout=0, overflow=0, zero=0. Internal operand, carry and chunk-index registers are cleared.
- Reset asserted mid-operation aborts the operation immediately. No partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: latch a into the A register. Latch b into the B register, or ~b if sub=1. Set the carry register to sub. Set chunk index to 0. Go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored and operands are not sampled.
  - Each cycle adds chunk i of A, chunk i of B and the carry register using a CHUNK-bit adder. Writes sum bits [i*CHUNK +: CHUNK], updates the carry register, increments i.
  - On the final chunk (i = NCH-1), also capture the carry into bit WIDTH-1 (c_msb) and the carry out of bit WIDTH-1 (c_out).
  - Then set carryout=c_out, overflow=c_out XOR c_msb, zero=(full sum==0), and go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, carryout, overflow and zero are held stable while out_valid=1 and out_ready=0; back-pressure is unbounded.
  - On out_ready=1 at a clock edge: out_valid falls and the state returns to IDLE. The result outputs keep their last values until the next completion.
- Latency: the accepting edge is edge 0; out_valid rises on edge NCH. Throughput is one operation per NCH+2 cycles minimum (accept, NCH RUN cycles, one DONE handshake cycle).
- The sum bits of chunks not yet computed are undefined to observers during RUN. Only values present while out_valid=1 are guaranteed.
- in_valid and out_ready are independent. in_valid held high during RUN/DONE does not queue a second operation; the pair is taken only once back in IDLE.
- Degenerate case CHUNK=WIDTH: NCH=1. RUN lasts one cycle and the block behaves as a registered single-cycle adder.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- WIDTH=16, CHUNK=4: a=0x0001, b=0x0001, sub=0 -> sum=0x0002, carryout=0, overflow=0, zero=0; out_valid rises exactly 4 edges after acceptance.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, carryout=0, overflow=1. Then a=0xFFFF, b=0x0001 -> sum=0x0000, carryout=1, overflow=0, zero=1.
- Subtract: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, carryout=1, overflow=1. Then a=0x0002, b=0x0003, sub=1 -> sum=0xFFFF, carryout=0, overflow=0.
- Back-pressure: hold out_ready=0 for 10 cycles after completion with in_valid=1 and new operands toggling -> in_ready=0 and outputs unchanged throughout. On out_ready=1, the block returns to IDLE and accepts the pending pair next cycle.
- Reset mid-RUN: assert rst_n=0 after chunk 1 -> outputs go to 0 and in_ready=1 without waiting for a clock edge. A following op 0x1234+0x4321 gives 0x5555.
- Parameter sweep: CHUNK in {1,4,16}, 500 random operand pairs each with random sub -> every result matches a reference model (sum, carryout, overflow, zero), and latency = WIDTH/CHUNK.
